hazard_ctrl_unit: RTL and testbench

//  Parametrised next-generation hazard detection unit for the 5-stage pipeline with I/D caches.

---
 rtl/hazard_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage pipeline: write enables and flushes from miss, branch and load-use
// events, a multi-cycle load-use bubble sequencer, saturating event counters and a miss watchdog.
module hazard_ctrl_unit #(
    parameter int REG_AW        = 5,
    parameter int JOP_W         = 2,
    parameter int LOAD_LAT      = 1,
    parameter int CNT_W         = 16,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IC_stall,
    input  logic              DC_stall,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic [REG_AW-1:0] EX_WR_out,
    input  logic              EX_MemtoReg,
    input  logic [JOP_W-1:0]  EX_JumpOP,
    input  logic              cnt_clr,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic              ID_EXWrite,
    output logic              EX_MWrite,
    output logic              M_WBWrite,
    output logic              IF_Flush,
    output logic              ID_Flush,
    output logic              Load_wait,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int RUN_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0] TO_V  = RUN_W'(STALL_TIMEOUT);
    localparam logic [RUN_W-1:0] TO_M1 = RUN_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
    localparam logic [1:0]       BUB_INIT = 2'(LOAD_LAT - 1);

    typedef enum logic {RUN, LDWAIT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic miss, br, ldhz;

    assign miss = IC_stall | DC_stall;
    assign br   = (EX_JumpOP != '0);
    assign ldhz = EX_MemtoReg && (EX_WR_out != '0) &&
                  ((EX_WR_out == ID_Rs) || (EX_WR_out == ID_Rt));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        ID_EXWrite = 1'b1;
        EX_MWrite  = 1'b1;
        M_WBWrite  = 1'b1;
        IF_Flush   = 1'b0;
        ID_Flush   = 1'b0;
        Load_wait  = 1'b0;
        state_d    = state_q;
        bub_d      = bub_q;
        if (miss) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXWrite = 1'b0;
            EX_MWrite  = 1'b0;
            M_WBWrite  = 1'b0;
        end else if (br) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
            state_d  = RUN;
            bub_d    = 2'd0;
        end else if ((state_q == LDWAIT) || ldhz) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_Flush   = 1'b1;
            Load_wait  = 1'b1;
            // Miss cycles never reach here, so they do not consume bubbles.
            if (state_q == LDWAIT) begin
                if (bub_q == 2'd1) begin
                    state_d = RUN;
                    bub_d   = 2'd0;
                end else begin
                    bub_d = bub_q - 2'd1;
                end
            end else if (LOAD_LAT > 1) begin
                state_d = LDWAIT;
                bub_d   = BUB_INIT;
            end
        end
    end

    always_comb begin
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            stall_cnt_d  = sat_inc(stall_cnt_q, miss);
            bubble_cnt_d = sat_inc(bubble_cnt_q, Load_wait);
            flush_cnt_d  = sat_inc(flush_cnt_q, IF_Flush);
        end
    end

    always_comb begin
        run_d           = '0;
        stall_timeout_d = stall_timeout_q;
        if ((STALL_TIMEOUT > 0) && miss)
            run_d = (run_q == TO_V) ? run_q : run_q + RUN_W'(1);
        // Fires once on the TO-th consecutive miss; the saturated run counter cannot re-fire it.
        if (cnt_clr)
            stall_timeout_d = 1'b0;
        else if ((STALL_TIMEOUT > 0) && miss && (run_q == TO_M1))
            stall_timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= RUN;
            bub_q           <= 2'd0;
            stall_cnt_q     <= '0;
            bubble_cnt_q    <= '0;
            flush_cnt_q     <= '0;
            run_q           <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bub_q           <= bub_d;
            stall_cnt_q     <= stall_cnt_d;
            bubble_cnt_q    <= bubble_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
            run_q           <= run_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (LOAD_LAT=3, CNT_W=4, STALL_TIMEOUT=4): the driver pushes
// hand-computed outputs plus modelled counter values, the monitor pops and compares each cycle.
module tb_hazard_ctrl_unit;

    localparam logic [7:0] DEF  = 8'b11111_000;
    localparam logic [7:0] MISS = 8'b00000_000;
    localparam logic [7:0] BR   = 8'b11111_110;
    localparam logic [7:0] BUB  = 8'b00111_011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       IC_stall = 1'b0, DC_stall = 1'b0, EX_MemtoReg = 1'b0, cnt_clr = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_WR_out = '0;
    logic [1:0] EX_JumpOP = '0;
    logic       PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite;
    logic       IF_Flush, ID_Flush, Load_wait, stall_timeout;
    logic [3:0] stall_cnt, bubble_cnt, flush_cnt;

    hazard_ctrl_unit #(.REG_AW(5), .JOP_W(2), .LOAD_LAT(3), .CNT_W(4), .STALL_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .IC_stall(IC_stall), .DC_stall(DC_stall),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_WR_out(EX_WR_out), .EX_MemtoReg(EX_MemtoReg),
        .EX_JumpOP(EX_JumpOP), .cnt_clr(cnt_clr),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EXWrite(ID_EXWrite),
        .EX_MWrite(EX_MWrite), .M_WBWrite(M_WBWrite), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
        .Load_wait(Load_wait), .stall_timeout(stall_timeout),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [7:0] outs;
        logic [3:0] sc, bc, fc;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] m_sc = '0, m_bc = '0, m_fc = '0;
    logic       m_to = 1'b0;
    int         m_run = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, ".outs"}, {PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite,
                                      IF_Flush, ID_Flush, Load_wait}, e.outs);
                chk({e.nm, ".stall_cnt"}, stall_cnt, e.sc);
                chk({e.nm, ".bubble_cnt"}, bubble_cnt, e.bc);
                chk({e.nm, ".flush_cnt"}, flush_cnt, e.fc);
                chk({e.nm, ".stall_timeout"}, stall_timeout, e.to);
            end
        end
    end

    function automatic logic [3:0] sinc(input logic [3:0] v, input logic en);
        return (en && v != 4'hF) ? v + 4'd1 : v;
    endfunction

    task automatic step(input string nm, input logic r, input logic ic, input logic dc,
                        input logic [1:0] jop, input logic mtr, input logic [4:0] wr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic clr,
                        input logic [7:0] eo);
        exp_t e;
        logic miss;
        @(posedge clk);
        #1;
        rst = r; IC_stall = ic; DC_stall = dc; EX_JumpOP = jop; EX_MemtoReg = mtr;
        EX_WR_out = wr; ID_Rs = rs; ID_Rt = rt; cnt_clr = clr;
        if (!r) begin
            m_sc = '0; m_bc = '0; m_fc = '0; m_to = 1'b0; m_run = 0;
        end
        e.nm = nm; e.outs = eo; e.sc = m_sc; e.bc = m_bc; e.fc = m_fc; e.to = m_to;
        q.push_back(e);
        if (r) begin
            miss = ic | dc;
            if (clr) begin
                m_sc = '0; m_bc = '0; m_fc = '0; m_to = 1'b0;
            end else begin
                m_sc = sinc(m_sc, miss);
                m_bc = sinc(m_bc, eo[0]);
                m_fc = sinc(m_fc, eo[2]);
                if (miss && m_run == 3) m_to = 1'b1;
            end
            m_run = miss ? ((m_run == 4) ? 4 : m_run + 1) : 0;
        end
    endtask

    task automatic idle(input string nm, input logic [7:0] eo);
        step(nm, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, eo);
    endtask

    task automatic ldhz(input string nm, input logic [7:0] eo);
        step(nm, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, eo);
    endtask

    task automatic misc(input string nm);
        step(nm, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MISS);
    endtask

    initial begin : driver
        int wait_cyc;
        step("reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, DEF);
        idle("post_reset", DEF);
        ldhz("ld_bub1", BUB);
        idle("ld_bub2", BUB);
        idle("ld_bub3", BUB);
        idle("ld_done", DEF);
        step("ld_r0", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, DEF);
        step("ld_rt_bub1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, BUB);
        step("dc_miss1", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MISS);
        step("dc_miss2", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, MISS);
        step("dc_miss3", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MISS);
        idle("rt_bub2", BUB);
        idle("rt_bub3", BUB);
        idle("rt_done", DEF);
        step("br_01", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, BR);
        step("br_ic_miss", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MISS);
        ldhz("abort_bub1", BUB);
        step("abort_br", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, BR);
        idle("abort_run", DEF);
        step("br_over_ld", 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, BR);
        idle("br_over_ld_run", DEF);
        for (int i = 0; i < 6; i++) misc($sformatf("wd_miss%0d", i));
        idle("wd_held", DEF);
        step("clr", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, DEF);
        idle("post_clr", DEF);
        for (int i = 0; i < 20; i++) misc($sformatf("sat_miss%0d", i));
        idle("sat_done", DEF);
        ldhz("rst_bub1", BUB);
        idle("rst_bub2", BUB);
        step("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, DEF);
        idle("rst_release", DEF);
        idle("rst_after", DEF);
        ldhz("final_bub1", BUB);
        idle("final_bub2", BUB);
        idle("final_bub3", BUB);
        idle("final_done", DEF);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule
